// File: rtl/rotate_sequencer.sv
// Multi-cycle rotate controller. A request is accepted in IDLE, the working register is
// rotated one bit per clock for operand2 mod WIDTH steps, and the result plus NEG/ZERO/CARRY/
// OVERFLOW status is held on a valid/ready response channel until consumed or aborted.
module rotate_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             leftRight,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  // Bits of operand2 above CW do not affect the rotate amount.
  logic unused_op2_hi;
  assign unused_op2_hi = ^operand2[WIDTH-1:CW];

  // One-bit rotate of the working register in the latched direction.
  always_comb begin
    step_val   = work_q;
    step_carry = 1'b0;
    if (dir_q) begin
      step_val   = {work_q[0], work_q[WIDTH-1:1]};
      step_carry = work_q[0];
    end else begin
      step_val   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      step_carry = work_q[WIDTH-1];
    end
  end

  // Next-state logic. A zero amount passes through ROTATE once without stepping so that the
  // response latency is max(amt,1) edges after the accept edge.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    status_d = status_q;
    count_d  = count_q;
    dir_d    = dir_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          work_d  = operand1;
          dir_d   = leftRight;
          count_d = operand2[CW-1:0];
          state_d = StRotate;
        end
      end
      StRotate: begin
        if (abort) begin
          state_d = StIdle;
        end else if (count_q == '0) begin
          state_d  = StDone;
          result_d = work_q;
          status_d = {work_q[WIDTH-1], work_q == '0, 1'b0, 1'b0};
        end else begin
          work_d  = step_val;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d  = StDone;
            result_d = step_val;
            status_d = {step_val[WIDTH-1], step_val == '0, step_carry, 1'b0};
          end
        end
      end
      StDone: begin
        // abort takes priority over a simultaneous rsp_ready; both return to IDLE.
        if (abort || rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      work_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      count_q  <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      status_q <= status_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = result_q;
    statusOut = status_q;
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer at WIDTH=8 with a queue-based scoreboard.
module tb_rotate_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         leftRight;
  logic         abort;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] result;
  logic [3:0]   statusOut;
  logic         busy;

  rotate_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .operand1  (operand1),
    .operand2  (operand2),
    .leftRight (leftRight),
    .abort     (abort),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .statusOut (statusOut),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   st;
    logic [7:0]   lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;

  // Reference rotate built from shifts; the carry is the last bit that wrapped, which lands
  // in bit 0 for a left rotate and in the MSB for a right rotate.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] op2,
                                 input logic dir);
    int           a;
    logic [W-1:0] r;
    exp_t         m;
    a = int'(op2) % W;
    if (dir) r = (x >> a) | (x << (W - a));
    else     r = (x << a) | (x >> (W - a));
    m.res = r;
    m.st  = {r[W-1], (r == '0), (a == 0) ? 1'b0 : (dir ? r[W-1] : r[0]), 1'b0};
    m.lat = (a == 0) ? 8'd1 : 8'(a);
    return m;
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after the accept edge with the
  // request inputs scrambled to show they are ignored after acceptance.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] a, input logic dir,
                       input bit expect_rsp);
    operand1  = x;
    operand2  = a;
    leftRight = dir;
    req_valid = 1'b1;
    if (expect_rsp) sb.push_back(model(x, a, dir));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    operand1  = W'($urandom);
    operand2  = W'($urandom);
    leftRight = 1'($urandom);
    @(negedge clk);
  endtask

  // Counts edges until rsp_valid, bounded; a timeout shows up as rsp_valid=0 in the checks.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
    operand1 = '0; operand2 = '0; leftRight = 1'b0;
    #12;
    total++;
    if ({req_ready, rsp_valid, busy} !== 3'b100)
      begin bad++; $display("FAIL reset_hs got=%b want=100", {req_ready, rsp_valid, busy}); end
    total++;
    if ({result, statusOut} !== 12'h000)
      begin bad++; $display("FAIL reset_data got=%h want=000", {result, statusOut}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_left_one();
    int lat;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL l1_ready got=%b want=1", req_ready); end
    issue(8'h81, 8'd1, 1'b0, 1'b1);
    wait_rsp(lat);
    e = sb.pop_front(); last_e = e;
    total++;
    if (rsp_valid !== 1'b1 || lat !== int'(e.lat))
      begin bad++; $display("FAIL l1_lat got=%0d/%b want=%0d", lat, rsp_valid, e.lat); end
    total++;
    if (result !== e.res) begin bad++; $display("FAIL l1_res got=%h want=%h", result, e.res); end
    total++;
    if (statusOut !== e.st) begin bad++; $display("FAIL l1_st got=%b want=%b", statusOut, e.st); end
    @(posedge clk); @(negedge clk);
    total++;
    if ({req_ready, busy, rsp_valid} !== 3'b100)
      begin bad++; $display("FAIL l1_idle got=%b want=100", {req_ready, busy, rsp_valid}); end
  endtask

  task automatic test_right_three();
    int lat;
    issue(8'hB4, 8'd3, 1'b1, 1'b1);
    wait_rsp(lat);
    e = sb.pop_front(); last_e = e;
    total++;
    if (rsp_valid !== 1'b1 || lat !== int'(e.lat))
      begin bad++; $display("FAIL r3_lat got=%0d/%b want=%0d", lat, rsp_valid, e.lat); end
    total++;
    if ({result, statusOut} !== {e.res, e.st})
      begin bad++; $display("FAIL r3_rsp got=%h/%b want=%h/%b", result, statusOut, e.res, e.st); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_modulo();
    int           lat;
    logic [W-1:0] ops[3];
    logic [W-1:0] amts[3];
    ops[0] = 8'h5A; amts[0] = 8'd8;
    ops[1] = 8'h01; amts[1] = 8'd11;
    ops[2] = 8'hC3; amts[2] = 8'd16;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], amts[i], 1'b0, 1'b1);
      wait_rsp(lat);
      e = sb.pop_front(); last_e = e;
      total++;
      if (rsp_valid !== 1'b1 || lat !== int'(e.lat))
        begin bad++; $display("FAIL mod%0d_lat got=%0d/%b want=%0d", i, lat, rsp_valid, e.lat); end
      total++;
      if ({result, statusOut} !== {e.res, e.st})
        begin
          bad++;
          $display("FAIL mod%0d_rsp got=%h/%b want=%h/%b", i, result, statusOut, e.res, e.st);
        end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_hold();
    int lat;
    bit ok;
    rsp_ready = 1'b0;
    issue(8'h00, 8'd5, 1'b0, 1'b1);
    wait_rsp(lat);
    e = sb.pop_front(); last_e = e;
    total++;
    if (rsp_valid !== 1'b1 || lat !== int'(e.lat) || {result, statusOut} !== {e.res, e.st})
      begin
        bad++;
        $display("FAIL hold_rsp got=%0d/%h/%b want=%0d/%h/%b", lat, result, statusOut, e.lat,
                 e.res, e.st);
      end
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {result, statusOut} !== {e.res, e.st})
        ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL hold_stable got=changed want=held"); end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({req_ready, rsp_valid} !== 2'b10)
      begin bad++; $display("FAIL hold_release got=%b want=10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    issue(8'hF0, 8'd7, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, busy} !== 3'b100)
      begin bad++; $display("FAIL abort_idle got=%b want=100", {req_ready, rsp_valid, busy}); end
    total++;
    if ({result, statusOut} !== {last_e.res, last_e.st})
      begin
        bad++;
        $display("FAIL abort_keep got=%h/%b want=%h/%b", result, statusOut, last_e.res, last_e.st);
      end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_norsp got=1 want=0"); end
    issue(8'h0F, 8'd4, 1'b0, 1'b1);
    wait_rsp(lat);
    e = sb.pop_front(); last_e = e;
    total++;
    if (rsp_valid !== 1'b1 || lat !== int'(e.lat) || {result, statusOut} !== {e.res, e.st})
      begin
        bad++;
        $display("FAIL abort_next got=%0d/%h/%b want=%0d/%h/%b", lat, result, statusOut, e.lat,
                 e.res, e.st);
      end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lat;
    issue(8'hF0, 8'd7, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, busy, result, statusOut} !== {3'b100, 12'h000})
      begin
        bad++;
        $display("FAIL arst got=%b%b%b/%h/%b want=100/00/0000", req_ready, rsp_valid, busy,
                 result, statusOut);
      end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h81, 8'd2, 1'b1, 1'b1);
    wait_rsp(lat);
    e = sb.pop_front(); last_e = e;
    total++;
    if (rsp_valid !== 1'b1 || lat !== int'(e.lat) || {result, statusOut} !== {e.res, e.st})
      begin
        bad++;
        $display("FAIL arst_next got=%0d/%h/%b want=%0d/%h/%b", lat, result, statusOut, e.lat,
                 e.res, e.st);
      end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int           lat;
    logic [W-1:0] x;
    logic [W-1:0] a;
    logic         d;
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom);
      a = W'($urandom);
      d = 1'($urandom);
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready got=0 want=1", i); end
      issue(x, a, d, 1'b1);
      wait_rsp(lat);
      e = sb.pop_front(); last_e = e;
      total++;
      if (rsp_valid !== 1'b1 || lat !== int'(e.lat) || {result, statusOut} !== {e.res, e.st})
        begin
          bad++;
          $display("FAIL b2b%0d x=%h a=%0d d=%b got=%0d/%h/%b want=%0d/%h/%b", i, x, a, d, lat,
                   result, statusOut, e.lat, e.res, e.st);
        end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_left_one();
    test_right_three();
    test_modulo();
    test_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
